// File: rtl/student_mux_if.sv
// Bundles the data, select and counter signals of student_mux.
// master drives a/b/sel/cnt_clr; slave is the mux itself.
interface student_mux_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sel;
  logic             cnt_clr;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;
  logic [CNT_W-1:0] sel_cnt;

  modport master (
    output a, b, sel, cnt_clr,
    input  out, out_q, sel_q, sel_cnt
  );

  modport slave (
    input  a, b, sel, cnt_clr,
    output out, out_q, sel_q, sel_cnt
  );
endinterface

// File: rtl/student_mux.sv
// Two-input selector. The combinational output needs no clock or reset;
// a registered copy, the registered select and a saturating count of
// select transitions sit alongside it for pipelined consumers and debug.
module student_mux #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  student_mux_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Pure data path: only a, b and sel reach the output, so an x/z select
  // resolves with the usual conditional-operator merge.
  assign bus.out = bus.sel ? bus.b : bus.a;

  // Next-state for the registered path; an unknown cnt_clr falls through
  // the if as a 0, and clear wins over a same-cycle increment.
  always_comb begin
    out_d = bus.sel ? bus.b : bus.a;
    sel_d = bus.sel;
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if ((bus.sel != sel_q) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Registered outputs; sel_q resets to 0 so a first sampled sel=1 counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      sel_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.out_q   = out_q;
  assign bus.sel_q   = sel_q;
  assign bus.sel_cnt = cnt_q;

endmodule

// File: tb/tb_student_mux.sv
// Directed bench for student_mux: one wide-counter instance and one
// 2-bit-counter instance for saturation.
module tb_student_mux;

  logic clk;
  logic rst_n;
  logic clk_en;
  int   n_cmp;
  int   n_err;

  student_mux_if #(.WIDTH(1), .CNT_W(8)) if0 ();
  student_mux_if #(.WIDTH(1), .CNT_W(2)) if1 ();

  student_mux #(.WIDTH(1), .CNT_W(8)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  student_mux #(.WIDTH(1), .CNT_W(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_comb_sweep();
    logic [7:0] exp_tab;
    logic [2:0] v;
    exp_tab = 8'b1101_1000; // bit i = expected out for (a,b,sel)=i
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      if0.a   = v[2];
      if0.b   = v[1];
      if0.sel = v[0];
      #1;
      n_cmp++;
      if (if0.out !== exp_tab[i]) begin
        n_err++;
        $display("FAIL comb_sweep abs=%b out=%b expected=%b", v, if0.out, exp_tab[i]);
      end
    end
  endtask

  task automatic test_sel_toggle();
    logic [2:0] sel_seq;
    logic [2:0] exp_seq;
    sel_seq = 3'b010;
    exp_seq = 3'b101;
    if0.a = 1'b1;
    if0.b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if0.sel = sel_seq[2-i];
      #1;
      n_cmp++;
      if (if0.out !== exp_seq[2-i]) begin
        n_err++;
        $display("FAIL sel_toggle step=%0d out=%b expected=%b", i, if0.out, exp_seq[2-i]);
      end
    end
  endtask

  task automatic test_reset();
    if0.cnt_clr = 1'b0;
    if1.cnt_clr = 1'b0;
    if1.a = 1'b0; if1.b = 1'b0; if1.sel = 1'b0;
    if0.sel = 1'b0;
    rst_n = 1'b0;
    #1;
    clk_en = 1'b1;
    n_cmp++;
    if (if0.out_q !== 1'b0) begin
      n_err++; $display("FAIL reset_out_q out_q=%b expected=0", if0.out_q);
    end
    n_cmp++;
    if (if0.sel_q !== 1'b0) begin
      n_err++; $display("FAIL reset_sel_q sel_q=%b expected=0", if0.sel_q);
    end
    n_cmp++;
    if (if0.sel_cnt !== 8'd0) begin
      n_err++; $display("FAIL reset_sel_cnt sel_cnt=%0d expected=0", if0.sel_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_registered();
    @(negedge clk);
    if0.a = 1'b1; if0.b = 1'b0; if0.sel = 1'b0;
    tick();
    n_cmp++;
    if (if0.out_q !== 1'b1 || if0.sel_q !== 1'b0) begin
      n_err++;
      $display("FAIL reg_sel0 out_q=%b sel_q=%b expected out_q=1 sel_q=0", if0.out_q, if0.sel_q);
    end
    @(negedge clk);
    if0.sel = 1'b1;
    n_cmp++;
    if (if0.out_q !== 1'b1) begin
      n_err++; $display("FAIL reg_hold out_q=%b expected=1 before edge", if0.out_q);
    end
    tick();
    n_cmp++;
    if (if0.out_q !== 1'b0 || if0.sel_q !== 1'b1) begin
      n_err++;
      $display("FAIL reg_sel1 out_q=%b sel_q=%b expected out_q=0 sel_q=1", if0.out_q, if0.sel_q);
    end
    n_cmp++;
    if (if0.sel_cnt !== 8'd1) begin
      n_err++; $display("FAIL first_sel_counts sel_cnt=%0d expected=1", if0.sel_cnt);
    end
  endtask

  task automatic test_counter();
    @(negedge clk);
    if0.cnt_clr = 1'b1;
    tick();
    n_cmp++;
    if (if0.sel_cnt !== 8'd0) begin
      n_err++; $display("FAIL cnt_clear sel_cnt=%0d expected=0", if0.sel_cnt);
    end
    @(negedge clk);
    if0.cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if0.sel = ~if0.sel;
      tick();
      n_cmp++;
      if (if0.sel_cnt !== 8'(i + 1)) begin
        n_err++; $display("FAIL cnt_toggle step=%0d sel_cnt=%0d expected=%0d", i, if0.sel_cnt, i + 1);
      end
      @(negedge clk);
    end
    tick();
    n_cmp++;
    if (if0.sel_cnt !== 8'd5) begin
      n_err++; $display("FAIL cnt_hold sel_cnt=%0d expected=5", if0.sel_cnt);
    end
    @(negedge clk);
    if0.sel = ~if0.sel;
    if0.cnt_clr = 1'b1;
    tick();
    n_cmp++;
    if (if0.sel_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_priority sel_cnt=%0d expected=0", if0.sel_cnt);
    end
    @(negedge clk);
    if0.cnt_clr = 1'b0;
    tick();
    n_cmp++;
    if (if0.sel_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_no_resync sel_cnt=%0d expected=0", if0.sel_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if1.sel = ~if1.sel;
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      tick();
      n_cmp++;
      if (if1.sel_cnt !== exp_cnt) begin
        n_err++; $display("FAIL saturate step=%0d sel_cnt=%0d expected=%0d", i, if1.sel_cnt, exp_cnt);
      end
      @(negedge clk);
    end
    tick();
    n_cmp++;
    if (if1.sel_cnt !== 2'd3) begin
      n_err++; $display("FAIL saturate_hold sel_cnt=%0d expected=3", if1.sel_cnt);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if1.a = 1'b1; if1.b = 1'b0; if1.sel = 1'b0;
    tick();
    n_cmp++;
    if (if1.out_q !== 1'b1 || if1.sel_cnt !== 2'd3) begin
      n_err++; $display("FAIL pre_reset out_q=%b sel_cnt=%0d expected out_q=1 sel_cnt=3", if1.out_q, if1.sel_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if1.out_q !== 1'b0 || if1.sel_q !== 1'b0 || if1.sel_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL mid_reset out_q=%b sel_q=%b sel_cnt=%0d expected all 0", if1.out_q, if1.sel_q, if1.sel_cnt);
    end
    n_cmp++;
    if (if1.out !== 1'b1) begin
      n_err++; $display("FAIL out_in_reset_a out=%b expected=1", if1.out);
    end
    if1.a = 1'b0; if1.b = 1'b1; if1.sel = 1'b1;
    #1;
    n_cmp++;
    if (if1.out !== 1'b1) begin
      n_err++; $display("FAIL out_in_reset_b out=%b expected=1", if1.out);
    end
    if1.b = 1'b0;
    #1;
    n_cmp++;
    if (if1.out !== 1'b0) begin
      n_err++; $display("FAIL out_in_reset_b0 out=%b expected=0", if1.out);
    end
    rst_n = 1'b1;
    if1.a = 1'b1; if1.sel = 1'b0;
    tick();
    n_cmp++;
    if (if1.out_q !== 1'b1 || if1.sel_q !== 1'b0 || if1.sel_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL post_release out_q=%b sel_q=%b sel_cnt=%0d expected 1/0/0", if1.out_q, if1.sel_q, if1.sel_cnt);
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    clk_en  = 1'b0;
    if0.cnt_clr = 1'b0;
    test_comb_sweep();
    test_sel_toggle();
    test_reset();
    test_registered();
    test_counter();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout compared=%0d expected completion before 20000", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
